// File: rtl/reduce_add_n_if.sv
`default_nettype none
// ============================================================================
// Module   : reduce_add_n_if
// Purpose  : Host load/collect handshake bundle for the N-operand reduction adder.
// Revision : 1.0
// ============================================================================
interface reduce_add_n_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 7
);
    logic                    r_enable;
    logic                    mode;
    logic [N_IN*WIDTH-1:0]   init_data;
    logic                    busy;
    logic                    w_enable;
    logic [WIDTH-1:0]        result;
    logic                    overflow;

    modport master (
        output r_enable, mode, init_data,
        input  busy, w_enable, result, overflow
    );

    modport slave (
        input  r_enable, mode, init_data,
        output busy, w_enable, result, overflow
    );
endinterface
`default_nettype wire

// File: rtl/reduce_add_n.sv
`default_nettype none
// ============================================================================
// Module   : reduce_add_n
// Purpose  : Loads N_IN operands and reduces them pairwise on N_ADD shared
//            adders (wrap or unsigned-saturate), pulsing w_enable when done.
// Revision : 1.0
// ============================================================================
module reduce_add_n #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 7,
    parameter int N_ADD = 2
) (
    input wire            clk,
    input wire            rst,
    reduce_add_n_if.slave bus
);

    localparam int c_LW    = $clog2(N_IN + 1);
    // Adders that can ever be used: never more pairs than operands allow.
    localparam int c_NPAIR = (N_ADD < N_IN / 2) ? N_ADD : N_IN / 2;
    localparam int c_NSLOT = (c_NPAIR > 0) ? c_NPAIR : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REDUCE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_load;
    logic               w_step;
    logic               w_done;

    logic [WIDTH-1:0]   r_ops  [N_IN];
    logic [WIDTH-1:0]   w_next [N_IN];
    logic [c_LW-1:0]    r_live;
    logic [c_LW-1:0]    w_half;
    logic [c_LW-1:0]    w_k;
    logic               r_mode;
    logic               r_ovf_acc;
    logic               w_step_ovf;

    logic [WIDTH-1:0]   w_sum [c_NSLOT];
    logic [c_NSLOT-1:0] w_cy;

    logic [WIDTH-1:0]   r_result;
    logic               r_overflow;
    logic               r_w_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.r_enable) begin
                    w_load       = 1'b1;
                    w_state_next = S_REDUCE;
                end
            end
            S_REDUCE: begin
                if (r_live == c_LW'(1)) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_step = 1'b1;
                end
            end
        endcase
    end

    assign w_half = r_live >> 1;
    assign w_k    = (w_half < c_LW'(c_NPAIR)) ? w_half : c_LW'(c_NPAIR);

    for (genvar j = 0; j < c_NSLOT; j++) begin : g_add
        if (j < c_NPAIR) begin : g_real
            logic [WIDTH:0] w_raw;
            assign w_raw    = {1'b0, r_ops[2*j]} + {1'b0, r_ops[2*j+1]};
            assign w_cy[j]  = w_raw[WIDTH];
            assign w_sum[j] = (r_mode && w_raw[WIDTH]) ? {WIDTH{1'b1}} : w_raw[WIDTH-1:0];
        end else begin : g_none
            assign w_cy[j]  = 1'b0;
            assign w_sum[j] = '0;
        end
    end

    // Leftover live values slide down by k; the first k slots take the sums.
    always_comb begin
        w_step_ovf = 1'b0;
        for (int j = 0; j < N_IN; j++) begin
            w_next[j] = r_ops[j];
        end
        for (int s = 0; s <= c_NPAIR; s++) begin
            for (int j = 0; j + s < N_IN; j++) begin
                if ((w_k == c_LW'(s)) && (c_LW'(j + s) < r_live)) begin
                    w_next[j] = r_ops[j + s];
                end
            end
        end
        for (int j = 0; j < c_NPAIR; j++) begin
            if (c_LW'(j) < w_k) begin
                w_next[j]  = w_sum[j];
                w_step_ovf = w_step_ovf | w_cy[j];
            end
        end
    end

    // Working registers need no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (w_load) begin
            for (int i = 0; i < N_IN; i++) begin
                r_ops[i] <= bus.init_data[i*WIDTH +: WIDTH];
            end
            r_live    <= c_LW'(N_IN);
            r_mode    <= bus.mode;
            r_ovf_acc <= 1'b0;
        end else if (w_step) begin
            r_ops     <= w_next;
            r_live    <= r_live - w_k;
            r_ovf_acc <= r_ovf_acc | w_step_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_w_enable <= 1'b0;
        end else begin
            r_w_enable <= w_done;
            if (w_done) begin
                r_result   <= r_ops[0];
                r_overflow <= r_ovf_acc;
            end else if (w_load) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign bus.busy     = (r_state == S_REDUCE);
    assign bus.w_enable = r_w_enable;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_reduce_add_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_reduce_add_n
// Purpose  : Scoreboard bench for reduce_add_n against an arithmetic sum model.
// Revision : 1.0
// ============================================================================
module tb_reduce_add_n;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb [$];
    exp_t mon_e;
    logic [31:0] v [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reduce_add_n_if #(.WIDTH(32), .N_IN(7)) ifa ();
    reduce_add_n_if #(.WIDTH(32), .N_IN(7)) ifb ();
    reduce_add_n_if #(.WIDTH(32), .N_IN(8)) ifc ();
    reduce_add_n_if #(.WIDTH(32), .N_IN(1)) ifd ();

    reduce_add_n #(.WIDTH(32), .N_IN(7), .N_ADD(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    reduce_add_n #(.WIDTH(32), .N_IN(7), .N_ADD(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    reduce_add_n #(.WIDTH(32), .N_IN(8), .N_ADD(4)) dut_c (.clk(clk), .rst(rst), .bus(ifc));
    reduce_add_n #(.WIDTH(32), .N_IN(1), .N_ADD(1)) dut_d (.clk(clk), .rst(rst), .bus(ifd));

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", nm, got, exp);
        end
    endtask

    // Sum of all operands in exact arithmetic; any carry happens iff it exceeds the width.
    function automatic logic [32:0] ref_sum(input logic [31:0] ops [8], input int n, input bit md);
        longint unsigned total = 0;
        for (int i = 0; i < n; i++) total += 64'(ops[i]);
        if (total <= 64'hFFFF_FFFF) return {1'b0, total[31:0]};
        return {1'b1, (md ? 32'hFFFF_FFFF : total[31:0])};
    endfunction

    function automatic int steps(input int n, input int nadd);
        int l = n;
        int c = 0;
        int k;
        while (l > 1) begin
            k = (l / 2 < nadd) ? l / 2 : nadd;
            l -= k;
            c++;
        end
        return c;
    endfunction

    // Called at a negedge; returns at the negedge after the load edge.
    task automatic drive_a(input logic [31:0] ops [8], input bit md, input bit track);
        exp_t        e;
        logic [32:0] m;
        for (int i = 0; i < 7; i++) ifa.init_data[i*32 +: 32] = ops[i];
        ifa.mode     = md;
        ifa.r_enable = 1'b1;
        if (track) begin
            m     = ref_sum(ops, 7, md);
            e.res = m[31:0];
            e.ovf = m[32];
            e.cyc = cyc + steps(7, 2) + 2;
            sb.push_back(e);
        end
        @(negedge clk);
        ifa.r_enable = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (ifa.busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (ifa.busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL a_idle_timeout: busy=%0b after %0d cycles, required 0", ifa.busy, t);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL a_drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && ifa.w_enable) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_w_enable: pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("a_result", 64'(ifa.result), 64'(mon_e.res));
                chk("a_overflow", 64'(ifa.overflow), 64'(mon_e.ovf));
                chk("a_latency", 64'(cyc), 64'(mon_e.cyc));
                chk("a_busy_in_done", 64'(ifa.busy), 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cnt;
        int          c0;
        int          pb, pc, pd;
        int          cb, cc, cd;
        logic [31:0] rb, rc, rd;
        logic [32:0] m;
        rst = 1'b1;
        ifa.r_enable = 1'b0; ifa.mode = 1'b0; ifa.init_data = '0;
        ifb.r_enable = 1'b0; ifb.mode = 1'b0; ifb.init_data = '0;
        ifc.r_enable = 1'b0; ifc.mode = 1'b0; ifc.init_data = '0;
        ifd.r_enable = 1'b0; ifd.mode = 1'b0; ifd.init_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_busy", 64'(ifa.busy), 64'd0);
        chk("rst_a_w_enable", 64'(ifa.w_enable), 64'd0);
        chk("rst_a_result", 64'(ifa.result), 64'd0);
        chk("rst_a_overflow", 64'(ifa.overflow), 64'd0);
        chk("rst_c_result", 64'(ifc.result), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Operands 1..7, wrap: busy five cycles, sum 28.
        for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
        drive_a(v, 1'b0, 1'b1);
        cnt = 0;
        while (ifa.busy && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        chk("a_busy_cycles", 64'(cnt), 64'd5);
        drain();

        // All-ones operands, wrap then saturate, back to back.
        for (int i = 0; i < 8; i++) v[i] = 32'hFFFF_FFFF;
        drive_a(v, 1'b0, 1'b1);
        wait_idle();
        drive_a(v, 1'b1, 1'b1);
        drain();

        // Asynchronous reset mid-reduction aborts the op.
        for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
        drive_a(v, 1'b0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy", 64'(ifa.busy), 64'd0);
        chk("async_rst_w_enable", 64'(ifa.w_enable), 64'd0);
        chk("async_rst_result", 64'(ifa.result), 64'd0);
        chk("async_rst_overflow", 64'(ifa.overflow), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        drive_a(v, 1'b0, 1'b1);
        drain();

        // Starts while busy are ignored; a start in the w_enable cycle is taken.
        for (int i = 0; i < 8; i++) v[i] = 32'hFFFF_FFFF;
        drive_a(v, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) begin
            ifa.r_enable  = 1'b1;
            ifa.mode      = 1'b1;
            ifa.init_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        ifa.r_enable = 1'b0;
        cnt = 0;
        while (!ifa.w_enable && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("a_w_enable_seen", 64'(ifa.w_enable), 64'd1);
        for (int i = 0; i < 8; i++) v[i] = 32'(i + 10);
        drive_a(v, 1'b0, 1'b1);
        chk("a_ovf_clear_at_load", 64'(ifa.overflow), 64'd0);
        chk("a_result_held", 64'(ifa.result), 64'hFFFF_FFF9);
        drain();

        // Random regression in both modes.
        for (int n = 0; n < 40; n++) begin
            wait_idle();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            for (int i = 0; i < 7; i++) begin
                case ($urandom_range(0, 2))
                    0:       v[i] = $urandom;
                    1:       v[i] = $urandom_range(0, 1000);
                    default: v[i] = 32'hFFFF_FF00 | $urandom_range(0, 255);
                endcase
            end
            drive_a(v, 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();

        // Other geometries: N_ADD=1, N_IN=8/N_ADD=4, single operand.
        for (int i = 0; i < 7; i++) ifb.init_data[i*32 +: 32] = 32'(i + 1);
        for (int i = 0; i < 8; i++) ifc.init_data[i*32 +: 32] = 32'(i + 1);
        ifd.init_data = 32'h5;
        ifb.r_enable = 1'b1; ifc.r_enable = 1'b1; ifd.r_enable = 1'b1;
        c0 = cyc;
        @(negedge clk);
        ifb.r_enable = 1'b0; ifc.r_enable = 1'b0; ifd.r_enable = 1'b0;
        pb = 0; pc = 0; pd = 0; cb = 0; cc = 0; cd = 0; rb = '0; rc = '0; rd = '0;
        for (int t = 0; t < 20; t++) begin
            if (ifb.w_enable) begin pb++; cb = cyc; rb = ifb.result; end
            if (ifc.w_enable) begin pc++; cc = cyc; rc = ifc.result; end
            if (ifd.w_enable) begin pd++; cd = cyc; rd = ifd.result; end
            @(negedge clk);
        end
        for (int i = 0; i < 8; i++) v[i] = 32'(i + 1);
        chk("b_pulses", 64'(pb), 64'd1);
        chk("b_latency", 64'(cb), 64'(c0 + steps(7, 1) + 2));
        m = ref_sum(v, 7, 1'b0);
        chk("b_result", 64'(rb), 64'(m[31:0]));
        chk("c_pulses", 64'(pc), 64'd1);
        chk("c_latency", 64'(cc), 64'(c0 + steps(8, 4) + 2));
        m = ref_sum(v, 8, 1'b0);
        chk("c_result", 64'(rc), 64'(m[31:0]));
        chk("c_overflow", 64'(ifc.overflow), 64'(m[32]));
        chk("d_pulses", 64'(pd), 64'd1);
        chk("d_latency", 64'(cd), 64'(c0 + steps(1, 1) + 2));
        chk("d_result", 64'(rd), 64'h5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
